// File: rtl/addi_seq_ctrl_if.sv
// Bus bundle between the sequencer and its IFU, register file and shared adder.
// master is the sequencer side; slave is the IFU/adder/register-file side.
interface addi_seq_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ifu_req;
  logic                  ifu_valid;
  logic [31:0]           inst;
  logic [DATA_WIDTH-1:0] result;
  logic [1:0]            adder_left_opt;
  logic [1:0]            adder_right_opt;
  logic                  rf_wen;
  logic [4:0]            rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport master (
    output ifu_req, adder_left_opt, adder_right_opt, rf_wen, rf_waddr, rf_wdata,
    input  ifu_valid, inst, result
  );

  modport slave (
    input  ifu_req, adder_left_opt, adder_right_opt, rf_wen, rf_waddr, rf_wdata,
    output ifu_valid, inst, result
  );
endinterface

// File: rtl/addi_seq_ctrl.sv
// Multi-cycle sequencer for the shared-adder CPU: fetch, decode, two execute cycles.
// Owns the PC; steers adder results to the register file or the PC.
module addi_seq_ctrl #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  addi_seq_ctrl_if.master       bus,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  halt,
  output logic                  illegal
);

  typedef enum logic [2:0] {StFetch, StDecode, StEx1, StEx2, StHalt} state_e;
  typedef enum logic [2:0] {OpAddi, OpAuipc, OpLui, OpJal, OpJalr, OpEbreak, OpIllegal} op_e;

  localparam logic [1:0] LeftSrc1  = 2'd0;
  localparam logic [1:0] LeftPc    = 2'd1;
  localparam logic [1:0] LeftZero  = 2'd2;
  localparam logic [1:0] RightImm  = 2'd0;
  localparam logic [1:0] RightFour = 2'd1;
  localparam logic [1:0] RightZero = 2'd2;

  state_e                state_q;
  logic [31:0]           inst_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] target_q;
  logic                  halt_q;
  logic                  illegal_q;

  op_e        op;
  logic [1:0] left_sel;
  logic [1:0] right_sel;
  logic       rf_slot;

  always_comb begin
    op = OpIllegal;
    if (inst_q == 32'h0010_0073) begin
      op = OpEbreak;
    end else begin
      case (inst_q[6:0])
        7'b0010011: if (inst_q[14:12] == 3'b000) op = OpAddi;
        7'b0010111: op = OpAuipc;
        7'b0110111: op = OpLui;
        7'b1101111: op = OpJal;
        7'b1100111: if (inst_q[14:12] == 3'b000) op = OpJalr;
        default:    op = OpIllegal;
      endcase
    end
  end

  // Select codes and the write slot are a pure function of state and latched inst.
  always_comb begin
    left_sel  = LeftZero;
    right_sel = RightZero;
    rf_slot   = 1'b0;
    if (state_q == StEx1) begin
      case (op)
        OpAddi:  begin left_sel = LeftSrc1; right_sel = RightImm;  rf_slot = 1'b1; end
        OpAuipc: begin left_sel = LeftPc;   right_sel = RightImm;  rf_slot = 1'b1; end
        OpLui:   begin left_sel = LeftZero; right_sel = RightImm;  rf_slot = 1'b1; end
        OpJal:   begin left_sel = LeftPc;   right_sel = RightFour; rf_slot = 1'b1; end
        OpJalr:  begin left_sel = LeftSrc1; right_sel = RightImm; end
        default: ;
      endcase
    end else if (state_q == StEx2) begin
      case (op)
        OpJal:   begin left_sel = LeftPc; right_sel = RightImm; end
        OpJalr:  begin left_sel = LeftPc; right_sel = RightFour; rf_slot = 1'b1; end
        default: begin left_sel = LeftPc; right_sel = RightFour; end
      endcase
    end
  end

  // rst masks everything so a write due in the reset cycle is dropped.
  assign bus.ifu_req         = (state_q == StFetch) && !rst;
  assign bus.adder_left_opt  = rst ? LeftZero  : left_sel;
  assign bus.adder_right_opt = rst ? RightZero : right_sel;
  assign bus.rf_wen          = rf_slot && (inst_q[11:7] != 5'd0) && !rst;
  assign bus.rf_waddr        = inst_q[11:7];
  assign bus.rf_wdata        = bus.result;
  assign pc                  = pc_q;
  assign halt                = halt_q && !rst;
  assign illegal             = illegal_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      target_q  <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (bus.ifu_valid) begin
            inst_q  <= bus.inst;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          case (op)
            OpEbreak: begin
              halt_q  <= 1'b1;
              state_q <= StHalt;
            end
            OpIllegal: begin
              halt_q    <= 1'b1;
              illegal_q <= 1'b1;
              state_q   <= StHalt;
            end
            default: state_q <= StEx1;
          endcase
        end
        StEx1: begin
          if (op == OpJalr) target_q <= {bus.result[DATA_WIDTH-1:1], 1'b0};
          state_q <= StEx2;
        end
        StEx2: begin
          pc_q    <= (op == OpJalr) ? target_q : bus.result;
          state_q <= StFetch;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_addi_seq_ctrl.sv
// Directed bench for addi_seq_ctrl; models the shared adder and checks hand-computed values.
module tb_addi_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        halt;
  logic        illegal;
  logic [31:0] src1;
  logic [31:0] imm;
  logic [31:0] lhs;
  logic [31:0] rhs;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  addi_seq_ctrl_if #(.DATA_WIDTH(32)) bus ();

  addi_seq_ctrl #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h8000_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pc     (pc),
    .halt   (halt),
    .illegal(illegal)
  );

  // Shared adder driven by the DUT's select codes.
  always_comb begin
    case (bus.adder_left_opt)
      2'd0:    lhs = src1;
      2'd1:    lhs = pc;
      default: lhs = '0;
    endcase
    case (bus.adder_right_opt)
      2'd0:    rhs = imm;
      2'd1:    rhs = 32'd4;
      default: rhs = '0;
    endcase
  end
  assign bus.result = lhs + rhs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ifu_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst ifu_req", bus.ifu_req, 0);
    check("rst rf_wen", bus.rf_wen, 0);
    check("rst left", bus.adder_left_opt, 2);
    check("rst right", bus.adder_right_opt, 2);
    check("rst halt", halt, 0);
    check("rst illegal", illegal, 0);
    rst = 1'b0;
    #1;
    check("rst pc", pc, 32'h8000_0000);
    check("rst fetch req", bus.ifu_req, 1);
  endtask

  // Zero-wait fetch of one instruction followed by its decode/EX1/EX2 checks.
  task automatic run_instr(input string tag, input logic [31:0] word, input logic [31:0] s1,
                           input logic [31:0] im, input logic [1:0] l1, input logic [1:0] r1,
                           input logic wen1, input logic [1:0] l2, input logic [1:0] r2,
                           input logic wen2, input logic [31:0] wdata, input logic [31:0] pc_next);
    src1 = s1;
    imm  = im;
    bus.inst = word;
    bus.ifu_valid = 1'b1;
    @(negedge clk);
    bus.inst = 32'hFFFF_FFFF;
    check({tag, " dec req"}, bus.ifu_req, 0);
    check({tag, " dec wen"}, bus.rf_wen, 0);
    @(negedge clk);
    bus.ifu_valid = 1'b0;
    check({tag, " ex1 left"}, bus.adder_left_opt, l1);
    check({tag, " ex1 right"}, bus.adder_right_opt, r1);
    check({tag, " ex1 wen"}, bus.rf_wen, wen1);
    if (wen1) begin
      check({tag, " ex1 waddr"}, bus.rf_waddr, word[11:7]);
      check({tag, " ex1 wdata"}, bus.rf_wdata, wdata);
    end
    @(negedge clk);
    check({tag, " ex2 left"}, bus.adder_left_opt, l2);
    check({tag, " ex2 right"}, bus.adder_right_opt, r2);
    check({tag, " ex2 wen"}, bus.rf_wen, wen2);
    if (wen2) begin
      check({tag, " ex2 waddr"}, bus.rf_waddr, word[11:7]);
      check({tag, " ex2 wdata"}, bus.rf_wdata, wdata);
    end
    @(negedge clk);
    check({tag, " next pc"}, pc, pc_next);
    check({tag, " next req"}, bus.ifu_req, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.ifu_valid = 1'b0;
    bus.inst = '0;
    src1 = '0;
    imm  = '0;
    do_reset();

    run_instr("addi x1", 32'h0050_0093, 0, 5, 0, 0, 1, 1, 1, 0, 32'd5, 32'h8000_0004);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait req", bus.ifu_req, 1);
      check("wait pc", pc, 32'h8000_0004);
    end

    run_instr("lui x3", 32'h1234_51B7, 0, 32'h1234_5000, 2, 0, 1, 1, 1, 0,
              32'h1234_5000, 32'h8000_0008);
    run_instr("auipc x4", 32'h0000_1217, 0, 32'h0000_1000, 1, 0, 1, 1, 1, 0,
              32'h8000_1008, 32'h8000_000C);
    run_instr("addi x0", 32'h0010_0013, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h8000_0010);

    do_reset();
    run_instr("jal x1", 32'h0100_00EF, 0, 16, 1, 1, 1, 1, 0, 0, 32'h8000_0004, 32'h8000_0010);

    do_reset();
    run_instr("jalr x5", 32'h0001_02E7, 32'h1234_5671, 0, 0, 0, 0, 1, 1, 1,
              32'h8000_0004, 32'h1234_5670);
    run_instr("jalr x0", 32'h0001_0067, 32'hFFFF_FFFD, 0, 0, 0, 0, 1, 1, 0, 0, 32'hFFFF_FFFC);
    run_instr("wrap", 32'h0010_0013, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h0000_0000);

    // Reset landing in EX1 must drop the write and reload the PC.
    src1 = 0;
    imm  = 5;
    bus.inst = 32'h0050_0093;
    bus.ifu_valid = 1'b1;
    @(negedge clk);
    bus.ifu_valid = 1'b0;
    @(negedge clk);
    check("ex1 pre-rst wen", bus.rf_wen, 1);
    rst = 1'b1;
    #1;
    check("ex1 rst wen", bus.rf_wen, 0);
    check("ex1 rst left", bus.adder_left_opt, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ex1 rst pc", pc, 32'h8000_0000);
    check("ex1 rst fetch", bus.ifu_req, 1);

    @(negedge clk);
    bus.inst = 32'h0010_0073;
    bus.ifu_valid = 1'b1;
    @(negedge clk);
    bus.ifu_valid = 1'b0;
    check("ebreak dec halt", halt, 0);
    @(negedge clk);
    check("ebreak halt", halt, 1);
    check("ebreak illegal", illegal, 0);
    bus.ifu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt req", bus.ifu_req, 0);
      check("halt pc", pc, 32'h8000_0000);
      check("halt sticky", halt, 1);
    end
    bus.ifu_valid = 1'b0;

    do_reset();
    bus.inst = 32'hFFFF_FFFF;
    bus.ifu_valid = 1'b1;
    @(negedge clk);
    bus.ifu_valid = 1'b0;
    @(negedge clk);
    check("illegal halt", halt, 1);
    check("illegal flag", illegal, 1);
    check("illegal req", bus.ifu_req, 0);
    check("illegal wen", bus.rf_wen, 0);

    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addi_seq_ctrl.md
Name: addi_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-instruction CPU's shared adder (src1/pc on the left, imm/4 on the right).
- Fetches one instruction per handshake and classifies it (addi, auipc, lui, jal, jalr, ebreak).
- Drives the adder's left/right select codes over two execute cycles, steering results to the register file or the PC.
- Owns the PC register; sits between the IFU, the register file and the adder.

Parameters:
DATA_WIDTH, 32, datapath and PC width
RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ifu_req  output  1  request next instruction at pc
ifu_valid  input  1  inst valid this cycle (handshake with ifu_req)
inst  input  32  fetched instruction word
result  input  DATA_WIDTH  adder sum for current select codes
adder_left_opt  output  2  0:src1, 1:pc, 2:zero
adder_right_opt  output  2  0:imm, 1:4, 2:zero
rf_wen  output  1  register file write enable this cycle
rf_waddr  output  5  destination register (inst[11:7])
rf_wdata  output  DATA_WIDTH  write data
pc  output  DATA_WIDTH  current PC
halt  output  1  sticky, set by ebreak or illegal opcode
illegal  output  1  sticky, set by unsupported opcode

Behaviour:
- Reset (sync, any state):
  - state=FETCH, pc=RESET_PC, inst latch=0, jump target latch=0.
  - halt=0, illegal=0, ifu_req=0 in the reset cycle.
  - adder opts=2/2, rf_wen=0.
- States: FETCH, DECODE, EX1, EX2, HALT. All outputs are Moore, decoded from state plus the latched inst.
- FETCH:
  - ifu_req=1.
  - On ifu_valid=1: latch inst, go to DECODE.
  - Otherwise stay; no timeout.
- DECODE (1 cycle): classify opcode/funct3/imm fields.
  - addi: opcode 0010011, funct3 000.
  - auipc: 0010111.
  - lui: 0110111.
  - jal: 1101111.
  - jalr: 1100111, funct3 000.
  - ebreak: exactly 32'h0010_0073.
  - ebreak: go to HALT with halt=1.
  - Any other encoding: go to HALT with halt=1 and illegal=1.
  - Otherwise go to EX1.
- EX1/EX2 select codes, with sampling at the end of each cycle:
  - addi: EX1 L0/R0, rf<=result. EX2 L1/R1, pc<=result.
  - auipc: EX1 L1/R0, rf<=result. EX2 L1/R1, pc<=result.
  - lui: EX1 L2/R0, rf<=result. EX2 L1/R1, pc<=result.
  - jal: EX1 L1/R1, rf<=result. EX2 L1/R0, pc<=result.
  - jalr: EX1 L0/R0, target<=result with bit0 cleared. EX2 L1/R1, rf<=result, pc<=target.
- Register file write:
  - rf_wen=1 only in the write cycle listed above, and only if rd!=0. rd=0 gives rf_wen=0.
  - rf_wdata=result, combinational pass-through.
- EX2 always transitions to FETCH. The PC update is visible on `pc` in the first FETCH cycle.
- Latency: FETCH(1+wait) + DECODE + EX1 + EX2, i.e. 4 cycles per instruction with zero-wait fetch.
- Outside EX1/EX2: opts=2/2, rf_wen=0.
- Arithmetic:
  - Modulo 2^DATA_WIDTH; wrap-around allowed (e.g. pc=FFFF_FFFC + 4 gives 0).
  - No overflow flag.
- HALT:
  - Absorbing; ifu_req=0, rf_wen=0, pc frozen.
  - Only rst exits.
- ifu_valid outside FETCH is ignored; no inst latch update.
- Reset asserted during EX1 (after an EX1 write was due): no rf write in that cycle. The pc reload has priority.

Test Plan:
- Reset then addi x1,x0,5 (32'h0050_0093), zero-wait fetch:
  - EX1 opts 0/0, rf_wen=1, waddr=1, wdata=result.
  - pc 8000_0000 -> 8000_0004 in the next FETCH.
  - 4 cycles/instr.
- jal x1,+16 at pc 8000_0000:
  - EX1 L1/R1, rf_wdata=8000_0004.
  - EX2 L1/R0, pc=8000_0010.
- jalr x5,0(x2) with adder result 1234_5671 in EX1:
  - EX2 writes x5=pc+4.
  - pc=1234_5670 (bit0 cleared).
- addi x0,x0,1:
  - rf_wen stays 0 in all cycles.
  - pc still advances by 4.
- ifu_valid held low for 3 cycles in FETCH:
  - ifu_req=1 throughout, no state change.
  - Decode occurs the cycle after ifu_valid rises.
- ebreak 32'h0010_0073 -> halt=1, illegal=0, ifu_req=0 forever. An illegal word 32'hFFFF_FFFF -> halt=1, illegal=1. rst during EX1 of an addi -> no rf write, pc=8000_0000, state FETCH on the next cycle.
